// File: rtl/stream_tx_source.sv
`default_nettype none
// ============================================================================
// Module   : stream_tx_source
// Brief    : Packet-aware ready/valid stream transmitter. A small FIFO takes
//            words from a local write port and drives them onto a tx
//            ready/valid bus. Packet statistics are kept alongside.
//            Optional macro STREAM_TX_PARITY_EN adds a per-word even-parity
//            output (tx_parity) that is stored with each entry.
// Revision : 1.0 - initial release
// ============================================================================
module stream_tx_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_last,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_last,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    word_count
`ifdef STREAM_TX_PARITY_EN
    ,
    output logic                    tx_parity
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SEND  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic                  r_mem_last [DEPTH];
`ifdef STREAM_TX_PARITY_EN
    logic                  r_mem_par  [DEPTH];
`endif

    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_pkt_open;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [CNT_WIDTH-1:0] r_word_count;

    logic                 w_push;
    logic                 w_pop;
    logic [c_LW-1:0]      w_level_next;

    // No pass-through at full: readiness depends on the registered level only
    assign wr_ready     = (r_level != c_FULL);
    assign w_push       = wr_valid && wr_ready;
    assign w_pop        = tx_valid && tx_ready;
    assign w_level_next = r_level + c_LW'(w_push) - c_LW'(w_pop);

    assign level      = r_level;
    assign pkt_count  = r_pkt_count;
    assign word_count = r_word_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= wr_data;
            r_mem_last[r_wr_ptr] <= wr_last;
`ifdef STREAM_TX_PARITY_EN
            r_mem_par[r_wr_ptr]  <= ^wr_data;
`endif
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at c_AW bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= w_level_next;
        end
    end

    // ------------------------------------------------------------------
    // Packet tracking and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_open   <= 1'b0;
            r_pkt_count  <= '0;
            r_word_count <= '0;
        end else if (w_pop) begin
            r_pkt_open   <= !tx_last;
            r_word_count <= r_word_count + CNT_WIDTH'(1);
            if (tx_last) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit gating state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A word already presented in SEND is committed, so losing enable then
    // finishes that packet in DRAIN rather than withdrawing tx_valid.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable && (w_level_next != '0)) begin
                    w_state_next = c_SEND;
                end
            end
            c_SEND: begin
                if (!enable) begin
                    if (w_pop) begin
                        w_state_next = tx_last ? c_IDLE : c_DRAIN;
                    end else if (tx_valid || r_pkt_open) begin
                        w_state_next = c_DRAIN;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end
            end
            c_DRAIN: begin
                if (enable) begin
                    w_state_next = c_SEND;
                end else if (w_pop && tx_last) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_valid = (r_state != c_IDLE) && (r_level != '0);
        tx_data  = '0;
        tx_last  = 1'b0;
`ifdef STREAM_TX_PARITY_EN
        tx_parity = 1'b0;
`endif
        if (tx_valid) begin
            tx_data  = r_mem_data[r_rd_ptr];
            tx_last  = r_mem_last[r_rd_ptr];
`ifdef STREAM_TX_PARITY_EN
            tx_parity = r_mem_par[r_rd_ptr];
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_tx_source.sv
`default_nettype none
// Directed bench for stream_tx_source (DATA_WIDTH=8, DEPTH=4, CNT_WIDTH=4):
// a vector table for enable/drain gating plus FIFO-model driven sequences.
module tb_stream_tx_source;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [2:0] level;
    logic [3:0] pkt_count;
    logic [3:0] word_count;
`ifdef STREAM_TX_PARITY_EN
    logic       tx_parity;
`endif

    stream_tx_source #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .level      (level),
        .pkt_count  (pkt_count),
        .word_count (word_count)
`ifdef STREAM_TX_PARITY_EN
        ,
        .tx_parity  (tx_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       en;
        logic       wv;
        logic [7:0] wd;
        logic       wl;
        logic       rdy;
        logic       e_tv;
        logic [7:0] e_td;
        logic       e_tl;
        logic [2:0] e_lvl;
        logic       e_wrr;
        logic [3:0] e_wc;
        logic [3:0] e_pc;
    } vec_t;

    vec_t tbl[14];

    // Reference FIFO for sequences run with enable held high: {last, data}
    logic [8:0] mq[$];
    logic [3:0] m_wc;
    logic [3:0] m_pc;

    task automatic step(input logic wv, input logic [7:0] wd, input logic wl, input logic rdy);
        logic       mpush;
        logic       mpop;
        logic [8:0] head;
        @(negedge clk);
        enable   = 1'b1;
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        tx_ready = rdy;
        head = (mq.size() != 0) ? mq[0] : 9'h000;
        chk("seq tx_valid",   32'(tx_valid),   32'(mq.size() != 0));
        chk("seq tx_data",    32'(tx_data),    32'(head[7:0]));
        chk("seq tx_last",    32'(tx_last),    32'(head[8]));
        chk("seq level",      32'(level),      32'(mq.size()));
        chk("seq wr_ready",   32'(wr_ready),   32'(mq.size() != 4));
        chk("seq word_count", 32'(word_count), 32'(m_wc));
        chk("seq pkt_count",  32'(pkt_count),  32'(m_pc));
        mpush = wv && (mq.size() != 4);
        mpop  = (mq.size() != 0) && rdy;
        @(posedge clk);
        if (mpop) begin
            m_wc = m_wc + 4'd1;
            if (head[8]) m_pc = m_pc + 4'd1;
            void'(mq.pop_front());
        end
        if (mpush) mq.push_back({wl, wd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq;
        logic       acc;

        //         en wv  wd    wl rdy | tv  td    tl lvl wrr wc     pc
        tbl[0]  = '{1, 1, 8'hA5, 1, 1,   1, 8'hA5, 1, 3'd1, 1, 4'd0, 4'd0};
        tbl[1]  = '{1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd0, 1, 4'd1, 4'd1};
        tbl[2]  = '{1, 1, 8'h01, 0, 0,   1, 8'h01, 0, 3'd1, 1, 4'd1, 4'd1};
        tbl[3]  = '{1, 1, 8'h02, 0, 1,   1, 8'h02, 0, 3'd1, 1, 4'd2, 4'd1};
        tbl[4]  = '{0, 1, 8'h03, 1, 0,   1, 8'h02, 0, 3'd2, 1, 4'd2, 4'd1};
        tbl[5]  = '{0, 1, 8'h04, 1, 1,   1, 8'h03, 1, 3'd2, 1, 4'd3, 4'd1};
        tbl[6]  = '{0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd1, 1, 4'd4, 4'd2};
        tbl[7]  = '{0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd1, 1, 4'd4, 4'd2};
        tbl[8]  = '{1, 0, 8'h00, 0, 0,   1, 8'h04, 1, 3'd1, 1, 4'd4, 4'd2};
        tbl[9]  = '{1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd0, 1, 4'd5, 4'd3};
        tbl[10] = '{0, 1, 8'h05, 1, 1,   0, 8'h00, 0, 3'd1, 1, 4'd5, 4'd3};
        tbl[11] = '{0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd1, 1, 4'd5, 4'd3};
        tbl[12] = '{1, 0, 8'h00, 0, 0,   1, 8'h05, 1, 3'd1, 1, 4'd5, 4'd3};
        tbl[13] = '{1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 3'd0, 1, 4'd6, 4'd4};

        rst_n    = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        wr_last  = 1'b0;
        tx_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset tx_valid",   32'(tx_valid),   32'd0);
        chk("reset tx_data",    32'(tx_data),    32'd0);
        chk("reset tx_last",    32'(tx_last),    32'd0);
        chk("reset level",      32'(level),      32'd0);
        chk("reset wr_ready",   32'(wr_ready),   32'd1);
        chk("reset word_count", 32'(word_count), 32'd0);
        chk("reset pkt_count",  32'(pkt_count),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Single word latency, packet drain on enable drop, idle hold
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            enable   = tbl[i].en;
            wr_valid = tbl[i].wv;
            wr_data  = tbl[i].wd;
            wr_last  = tbl[i].wl;
            tx_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d tx_valid", i),   32'(tx_valid),   32'(tbl[i].e_tv));
            chk($sformatf("row%0d tx_data", i),    32'(tx_data),    32'(tbl[i].e_td));
            chk($sformatf("row%0d tx_last", i),    32'(tx_last),    32'(tbl[i].e_tl));
            chk($sformatf("row%0d level", i),      32'(level),      32'(tbl[i].e_lvl));
            chk($sformatf("row%0d wr_ready", i),   32'(wr_ready),   32'(tbl[i].e_wrr));
            chk($sformatf("row%0d word_count", i), 32'(word_count), 32'(tbl[i].e_wc));
            chk($sformatf("row%0d pkt_count", i),  32'(pkt_count),  32'(tbl[i].e_pc));
        end

        mq.delete();
        m_wc = 4'd6;
        m_pc = 4'd4;

        // Fill to full under backpressure; fifth write is refused
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h10 + 8'(i), (i >= 3), 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        // Pop while full: push must still be refused
        step(1'b1, 8'h14, 1'b1, 1'b1);
        #1 chk("full pop no passthrough level", 32'(level), 32'd3);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end

        // Push/pop around level DEPTH-1 with random backpressure
        seq = 8'h40;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq, ((seq % 3) == 2), 1'b0);
            seq = seq + 8'd1;
        end
        for (int i = 0; i < 40; i++) begin
            acc = (mq.size() != 4);
            step(1'b1, seq, ((seq % 3) == 2), 1'($urandom_range(0, 1)));
            if (acc) seq = seq + 8'd1;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end

        // Walk pkt_count to all-ones with single-word packets, then wrap
        for (int i = 0; i < 64 && m_pc != 4'hF; i++) begin
            step((4'(m_pc + 4'(mq.size())) != 4'hF), 8'hC0 + 8'(i), 1'b1, 1'b1);
        end
        #1 chk("pkt_count all-ones", 32'(pkt_count), 32'd15);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        #1 chk("pkt_count wrapped", 32'(pkt_count), 32'd0);

        // Asynchronous reset mid-packet with three words queued
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        #1;
        chk("pre-reset level",    32'(level),    32'd3);
        chk("pre-reset tx_valid", 32'(tx_valid), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async reset tx_valid",   32'(tx_valid),   32'd0);
        chk("async reset level",      32'(level),      32'd0);
        chk("async reset word_count", 32'(word_count), 32'd0);
        chk("async reset pkt_count",  32'(pkt_count),  32'd0);
        chk("async reset wr_ready",   32'(wr_ready),   32'd1);
        chk("async reset tx_data",    32'(tx_data),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mq.delete();
        m_wc = 4'd0;
        m_pc = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        step(1'b1, 8'h77, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        chk("post-reset word_count", 32'(word_count), 32'd1);
        chk("post-reset pkt_count",  32'(pkt_count),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
